// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int   WCNT_W   = 3;
endpackage

// File: rtl/arb_pick2.sv
// Two-request winner select; on a tie the port not granted last wins.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner
);
  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1)
      winner = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    else if (req1)
      winner = PORT_DMA;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) async SRAM arbiter: SETUP / STROBE(WAIT_STATES+1) / HOLD.
// Optional round-robin tie-break: MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        nclk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_d_oe,
  input  logic [7:0]  mem_din,
  output logic        n_mem_oe,
  output logic        n_mem_we,
  output logic        busy
);
  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  cnt;
  logic               wr_q, idx_q;
  logic               winner, last_grant, grant, strobe_last;

  assign grant       = (state == IDLE) && (req0 || req1);
  assign strobe_last = (state == STROBE) && (cnt == '0);

  arb_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .winner     (winner)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst)       last_grant <= PORT_DMA;
    else if (grant) last_grant <= winner;
  end
`else
  // Tied to DMA so the picker always favours the CPU on a tie.
  assign last_grant = PORT_DMA;
`endif

  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    n_mem_oe  = 1'b1;
    n_mem_we  = 1'b1;
    mem_d_oe  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_nxt = SETUP;
      end
      SETUP: begin
        mem_d_oe  = wr_q;
        state_nxt = STROBE;
      end
      STROBE: begin
        mem_d_oe = wr_q;
        n_mem_oe = wr_q;
        n_mem_we = !wr_q;
        if (cnt == '0) state_nxt = HOLD;
      end
      HOLD: begin
        mem_d_oe  = wr_q;
        ack0      = (idx_q == PORT_CPU);
        ack1      = (idx_q == PORT_DMA);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, wait counter and read capture.
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      mem_a    <= '0;
      mem_dout <= '0;
      wr_q     <= 1'b0;
      idx_q    <= PORT_CPU;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (grant) begin
        idx_q    <= winner;
        mem_a    <= (winner == PORT_DMA) ? addr1  : addr0;
        mem_dout <= (winner == PORT_DMA) ? wdata1 : wdata0;
        wr_q     <= (winner == PORT_DMA) ? wr1    : wr0;
      end
      if (state == SETUP)
        cnt <= WCNT_W'(WAIT_STATES);
      else if (state == STROBE && cnt != '0)
        cnt <= cnt - 1'b1;
      if (strobe_last && !wr_q)
        rdata <= mem_din;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; WAIT_STATES 1 main instance plus 0 and 7 instances.
module tb_mem_arbiter;
  logic        nclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0, mem_din = '0;

  logic        ack0, ack1, mem_d_oe, n_mem_oe, n_mem_we, busy;
  logic [7:0]  rdata, mem_dout;
  logic [15:0] mem_a;
  logic        z_ack0, z_ack1, z_doe, z_oe, z_we, z_busy;
  logic [7:0]  z_rdata, z_dout;
  logic [15:0] z_a;
  logic        s_ack0, s_ack1, s_doe, s_oe, s_we, s_busy;
  logic [7:0]  s_rdata, s_dout;
  logic [15:0] s_a;

  int errors = 0, checks = 0;
  int msel = 0;
  logic m_ack0, m_ack1, m_doe, m_oe, m_we;
  int oe_cnt, we_cnt, doe_cnt, both_low, both_ack, ack0_cnt, ack1_cnt, ack0_cyc, ack1_cyc;
  int win[$];

  always #5 nclk = ~nclk;

  mem_arbiter #(.WAIT_STATES(1)) dut (
    .nclk(nclk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_d_oe(mem_d_oe), .mem_din(mem_din), .n_mem_oe(n_mem_oe), .n_mem_we(n_mem_we),
    .busy(busy));

  mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .nclk(nclk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(z_ack0), .ack1(z_ack1), .rdata(z_rdata), .mem_a(z_a), .mem_dout(z_dout),
    .mem_d_oe(z_doe), .mem_din(mem_din), .n_mem_oe(z_oe), .n_mem_we(z_we),
    .busy(z_busy));

  mem_arbiter #(.WAIT_STATES(7)) dut7 (
    .nclk(nclk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .mem_a(s_a), .mem_dout(s_dout),
    .mem_d_oe(s_doe), .mem_din(mem_din), .n_mem_oe(s_oe), .n_mem_we(s_we),
    .busy(s_busy));

  always_comb begin
    case (msel)
      1:       {m_ack0, m_ack1, m_doe, m_oe, m_we} = {z_ack0, z_ack1, z_doe, z_oe, z_we};
      2:       {m_ack0, m_ack1, m_doe, m_oe, m_we} = {s_ack0, s_ack1, s_doe, s_oe, s_we};
      default: {m_ack0, m_ack1, m_doe, m_oe, m_we} = {ack0, ack1, mem_d_oe, n_mem_oe, n_mem_we};
    endcase
  end

  task automatic step();
    @(posedge nclk); #1;
  endtask

  task automatic settle();
    repeat (12) step();
  endtask

  // Observe n cycles after the current one; cycle 1 is the first edge's result.
  task automatic measure(input int sel, input int n, input bit drop);
    msel = sel;
    oe_cnt = 0; we_cnt = 0; doe_cnt = 0; both_low = 0; both_ack = 0;
    ack0_cnt = 0; ack1_cnt = 0; ack0_cyc = -1; ack1_cyc = -1;
    win.delete();
    for (int c = 1; c <= n; c++) begin
      step();
      if (drop && c == 1) begin req0 = 0; req1 = 0; end
      if (!m_oe) oe_cnt++;
      if (!m_we) we_cnt++;
      if (m_doe) doe_cnt++;
      if (!m_oe && !m_we) both_low++;
      if (m_ack0 && m_ack1) both_ack++;
      if (m_ack0) begin ack0_cnt++; ack0_cyc = c; win.push_back(0); end
      if (m_ack1) begin ack1_cnt++; ack1_cyc = c; win.push_back(1); end
    end
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    rst = 0;
    repeat (2) step();
    rst = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 1; #2; rst = 0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({n_mem_oe, n_mem_we} !== 2'b11) begin errors++; $display("FAIL rst_strobes got=%b exp=11", {n_mem_oe, n_mem_we}); end
    checks++; if ({mem_d_oe, ack0, ack1} !== 3'b000) begin errors++; $display("FAIL rst_oe_acks got=%b exp=000", {mem_d_oe, ack0, ack1}); end
    checks++; if ({mem_a, mem_dout, rdata} !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=00000000", {mem_a, mem_dout, rdata}); end
    repeat (2) step();
    rst = 1;
    step();
  endtask

  task automatic test_cpu_read();
    req0 = 1; wr0 = 0; addr0 = 16'h1234; wdata0 = 8'hEE; mem_din = 8'hA5;
    measure(0, 6, 1);
    checks++; if (oe_cnt !== 2) begin errors++; $display("FAIL cpu_rd_oe_width got=%0d exp=2", oe_cnt); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL cpu_rd_we_low got=%0d exp=0", we_cnt); end
    checks++; if (ack0_cyc !== 4 || ack0_cnt !== 1) begin errors++; $display("FAIL cpu_rd_ack got=cyc%0d/n%0d exp=cyc4/n1", ack0_cyc, ack0_cnt); end
    checks++; if (ack1_cnt !== 0) begin errors++; $display("FAIL cpu_rd_ack1 got=%0d exp=0", ack1_cnt); end
    checks++; if (doe_cnt !== 0) begin errors++; $display("FAIL cpu_rd_doe got=%0d exp=0", doe_cnt); end
    mem_din = 8'h00;
    step();
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL cpu_rd_rdata got=%h exp=a5", rdata); end
    checks++; if (mem_a !== 16'h1234) begin errors++; $display("FAIL cpu_rd_addr_hold got=%h exp=1234", mem_a); end
    settle();
  endtask

  task automatic test_dma_write();
    req1 = 1; wr1 = 1; addr1 = 16'h8000; wdata1 = 8'h3C;
    measure(0, 7, 1);
    checks++; if (we_cnt !== 2) begin errors++; $display("FAIL dma_wr_we_width got=%0d exp=2", we_cnt); end
    checks++; if (oe_cnt !== 0) begin errors++; $display("FAIL dma_wr_oe_low got=%0d exp=0", oe_cnt); end
    checks++; if (doe_cnt !== 4) begin errors++; $display("FAIL dma_wr_doe_width got=%0d exp=4", doe_cnt); end
    checks++; if (ack1_cnt !== 1 || ack1_cyc !== 4 || ack0_cnt !== 0) begin errors++; $display("FAIL dma_wr_ack got=n%0d/cyc%0d/a0n%0d exp=n1/cyc4/a0n0", ack1_cnt, ack1_cyc, ack0_cnt); end
    checks++; if ({mem_a, mem_dout} !== 24'h80003C) begin errors++; $display("FAIL dma_wr_bus got=%h exp=80003c", {mem_a, mem_dout}); end
    checks++; if ({mem_d_oe, busy} !== 2'b00) begin errors++; $display("FAIL dma_wr_idle got=%b exp=00", {mem_d_oe, busy}); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL dma_wr_rdata_hold got=%h exp=a5", rdata); end
    wr1 = 0;
    settle();
  endtask

  task automatic test_back_to_back();
    int exp_w[4];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_w = '{0, 1, 0, 1};
`else
    exp_w = '{0, 0, 0, 0};
`endif
    do_reset();
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 16'h0010; addr1 = 16'h0020;
    measure(0, 20, 0);
    req0 = 0; req1 = 0;
    checks++; if (win.size() !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", win.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= win.size() || win[i] !== exp_w[i]) begin
        errors++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, (i < win.size()) ? win[i] : -1, exp_w[i]);
      end
    end
    checks++; if (both_ack !== 0 || both_low !== 0) begin errors++; $display("FAIL b2b_exclusive got=%0d/%0d exp=0/0", both_ack, both_low); end
    settle();
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    req1 = 1; wr1 = 1; addr1 = 16'h4444; wdata1 = 8'h77;
    step();
    req1 = 0;
    step();
    checks++; if (n_mem_we !== 1'b0) begin errors++; $display("FAIL midrst_pre_strobe got=%b exp=0", n_mem_we); end
    rst = 0; #1;
    checks++; if ({n_mem_oe, n_mem_we, mem_d_oe, busy} !== 4'b1100) begin errors++; $display("FAIL midrst_async got=%b exp=1100", {n_mem_oe, n_mem_we, mem_d_oe, busy}); end
    checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL midrst_addr got=%h exp=0000", mem_a); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack0 || ack1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack got=%0d exp=0", acks); end
    rst = 1;
    req0 = 1; wr0 = 0; addr0 = 16'h0042; mem_din = 8'h5A;
    measure(0, 6, 1);
    checks++; if (ack0_cyc !== 4 || ack1_cnt !== 0) begin errors++; $display("FAIL midrst_after got=cyc%0d/a1n%0d exp=cyc4/a1n0", ack0_cyc, ack1_cnt); end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL midrst_rdata got=%h exp=5a", rdata); end
    settle();
  endtask

  task automatic test_wait_states();
    req0 = 1; wr0 = 0; addr0 = 16'h0100; mem_din = 8'h99;
    measure(1, 6, 1);
    checks++; if (ack0_cyc !== 3 || ack0_cnt !== 1) begin errors++; $display("FAIL ws0_ack got=cyc%0d/n%0d exp=cyc3/n1", ack0_cyc, ack0_cnt); end
    checks++; if (oe_cnt !== 1) begin errors++; $display("FAIL ws0_oe_width got=%0d exp=1", oe_cnt); end
    checks++; if (z_rdata !== 8'h99) begin errors++; $display("FAIL ws0_rdata got=%h exp=99", z_rdata); end
    settle();
    req1 = 1; wr1 = 1; addr1 = 16'h0200; wdata1 = 8'h11;
    measure(2, 13, 1);
    checks++; if (ack1_cyc !== 10 || ack1_cnt !== 1) begin errors++; $display("FAIL ws7_ack got=cyc%0d/n%0d exp=cyc10/n1", ack1_cyc, ack1_cnt); end
    checks++; if (we_cnt !== 8 || oe_cnt !== 0) begin errors++; $display("FAIL ws7_we_width got=%0d/%0d exp=8/0", we_cnt, oe_cnt); end
    checks++; if (s_dout !== 8'h11) begin errors++; $display("FAIL ws7_dout got=%h exp=11", s_dout); end
    wr1 = 0;
    settle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_reset_mid_write();
    test_wait_states();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1 (legal range 0..7), giving extra strobe cycles per access.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port nclk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have ports req0, req1  input  1 each  access request from port 0 (CPU core) and port 1 (DMA/loader).
REQ-005 SHALL have ports wr0, wr1  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports addr0, addr1  input  16 each  access address.
REQ-007 SHALL have ports wdata0, wdata1  input  8 each  write data.
REQ-008 SHALL have ports ack0, ack1  output  1 each  one-cycle transaction-done pulse.
REQ-009 SHALL have port rdata  output  8  read data, shared by both ports.
REQ-010 SHALL have port mem_a  output  16  memory address.
REQ-011 SHALL have ports mem_dout  output  8  and  mem_d_oe  output  1  (write data and its drive enable).
REQ-012 SHALL have port mem_din  input  8  memory read data.
REQ-013 SHALL have ports n_mem_oe, n_mem_we  output  1 each  active-low memory strobes.
REQ-014 SHALL have port busy  output  1  high in any non-IDLE state.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD.
REQ-016 In IDLE with req0 or req1 high, SHALL pick a winner, latch its addr/wdata/wr and index, and enter SETUP.
REQ-017 SETUP SHALL last 1 cycle: mem_a driven, both strobes high, mem_d_oe = latched wr.
REQ-018 STROBE SHALL last WAIT_STATES+1 cycles via 3-bit down-counter: n_mem_oe low for reads, n_mem_we low for writes.
REQ-019 On the last STROBE edge, a read SHALL capture mem_din into rdata; rdata SHALL hold until the next read capture.
REQ-020 HOLD SHALL last 1 cycle: strobes high, mem_a/mem_dout/mem_d_oe unchanged, ack of winner high; then IDLE.
REQ-021 Latency from req sampled in IDLE to ack SHALL be exactly WAIT_STATES+3 cycles; next grant no earlier than the cycle after HOLD.
REQ-022 Request changes after latching SHALL be ignored; a dropped req SHALL still complete and ack.
REQ-023 ack0 and ack1 SHALL never be high simultaneously; never both strobes low.
REQ-024 mem_a and mem_dout SHALL hold last latched values in IDLE; mem_d_oe SHALL be 0 in IDLE.
REQ-025 WAIT_STATES = 0 SHALL give a single-cycle STROBE with no counter underflow.

Reset
REQ-026 rst low SHALL asynchronously force IDLE, n_mem_oe = n_mem_we = 1, mem_d_oe = 0, ack0 = ack1 = 0, busy = 0, mem_a = 0, mem_dout = 0, rdata = 0, last-grant = port 1.
REQ-027 Reset mid-transaction SHALL abort it without ack; first edge after release SHALL behave as IDLE.

Configuration
REQ-028 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on simultaneous requests the port not granted last SHALL win; last-grant updates on each grant.
REQ-029 Macro undefined: port 0 SHALL always win ties (fixed priority, port 1 may starve); last-grant register absent.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the FSM state enum, port index constants PORT_CPU = 0 / PORT_DMA = 1, and the wait counter width constant.
REQ-031 Winner selection SHALL be a sub-module arb_pick2 (req0, req1, last-grant in; winner index out); the FSM, datapath latches and strobes stay in mem_arbiter.

Verification
REQ-032 CPU read, WAIT_STATES = 1, addr0 = 0x1234, mem_din = 0xA5 -> n_mem_oe low 2 cycles, ack0 on cycle 4, rdata = 0xA5, n_mem_we stays high.
REQ-033 DMA write, addr1 = 0x8000, wdata1 = 0x3C -> mem_d_oe high SETUP..HOLD, n_mem_we low WAIT_STATES+1 cycles, mem_dout = 0x3C, ack1 once.
REQ-034 req0 and req1 held high for 4 transactions -> RR_EN: grants 0,1,0,1 (first tie after reset to port 0); no RR_EN: 0,0,0,0.
REQ-035 rst low during STROBE of a write -> strobes high and mem_d_oe 0 immediately, no ack, next request after release completes normally.
REQ-036 WAIT_STATES = 0 and WAIT_STATES = 7 -> ack latency 3 and 10 cycles, strobe width 1 and 8 cycles.
